// File: rtl/sram_mmio_responder.sv
// sram_mmio_responder: word RAM plus LED/switch/timer MMIO page behind the CPU data SRAM port
module sram_mmio_responder #(
  parameter int          RAM_AW    = 12,
  parameter logic [15:0] MMIO_BASE = 16'hBFAF,
  parameter int          LED_W     = 16,
  parameter int          SW_W      = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             data_sram_en,
  input  logic [3:0]       data_sram_wen,
  input  logic [31:0]      data_sram_addr,
  input  logic [31:0]      data_sram_wdata,
  output logic [31:0]      data_sram_rdata,
  input  logic [SW_W-1:0]  switch_i,
  output logic [LED_W-1:0] led_o,
  output logic             timer_int
);
  localparam logic [13:0] OFF_LED  = 14'(16'hF000 >> 2);
  localparam logic [13:0] OFF_SW   = 14'(16'hF004 >> 2);
  localparam logic [13:0] OFF_CNT  = 14'(16'hE000 >> 2);
  localparam logic [13:0] OFF_CMP  = 14'(16'hE004 >> 2);
  localparam logic [13:0] OFF_CTRL = 14'(16'hE008 >> 2);

  logic [31:0]       mem [0:(1<<RAM_AW)-1];
  logic [LED_W-1:0]  led;
  logic [31:0]       count, compare, rdata, mmio_rd, ram_rd, bmask, led_w;
  logic              ctrl_en, ctrl_ie, pending;
  logic              mmio_sel, wr, rd, wr_led, wr_cnt, wr_cmp, wr_ctrl, match, clr;
  logic [RAM_AW-1:0] idx;
  logic [13:0]       off;
  logic              unused;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [31:0] m);
    return (old & ~m) | (d & m);
  endfunction

  assign mmio_sel  = data_sram_addr[31:16] == MMIO_BASE;
  assign idx       = data_sram_addr[RAM_AW+1:2];
  assign off       = data_sram_addr[15:2];
  assign wr        = data_sram_en && |data_sram_wen;
  assign rd        = data_sram_en && data_sram_wen == 4'b0000;
  assign bmask     = {{8{data_sram_wen[3]}}, {8{data_sram_wen[2]}}, {8{data_sram_wen[1]}}, {8{data_sram_wen[0]}}};
  assign wr_led    = wr && mmio_sel && off == OFF_LED;
  assign wr_cnt    = wr && mmio_sel && off == OFF_CNT;
  assign wr_cmp    = wr && mmio_sel && off == OFF_CMP;
  assign wr_ctrl   = wr && mmio_sel && off == OFF_CTRL;
  assign match     = ctrl_en && count == compare;
  assign clr       = wr_ctrl && data_sram_wen[0] && data_sram_wdata[2];
  assign led_w     = merge(32'(led), data_sram_wdata, bmask);
  assign ram_rd    = mem[idx];
  assign led_o     = led;
  assign timer_int = pending & ctrl_ie;
  assign data_sram_rdata = rdata;
  assign unused    = ^{data_sram_addr[1:0], led_w};

  // MMIO read mux; unmapped offsets read as zero
  always_comb begin
    mmio_rd = off == OFF_LED  ? 32'(led) :
              off == OFF_SW   ? 32'(switch_i) :
              off == OFF_CNT  ? count :
              off == OFF_CMP  ? compare :
              off == OFF_CTRL ? {29'b0, pending, ctrl_ie, ctrl_en} : 32'b0;
  end

  // RAM byte-lane writes; contents survive reset
  always_ff @(posedge clk) begin
    if (resetn && wr && !mmio_sel)
      for (int i = 0; i < 4; i++)
        if (data_sram_wen[i]) mem[idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
  end

  // Registered read data, only updated by a read request
  always_ff @(posedge clk) begin
    if (!resetn) rdata <= 32'b0;
    else if (rd) rdata <= mmio_sel ? mmio_rd : ram_rd;
  end

  // LED, timer and interrupt state; a CPU write to COUNT overrides the increment and a match beats W1C
  always_ff @(posedge clk) begin
    if (!resetn) begin
      led     <= '0;
      count   <= 32'b0;
      compare <= 32'hFFFF_FFFF;
      ctrl_en <= 1'b0;
      ctrl_ie <= 1'b0;
      pending <= 1'b0;
    end else begin
      if (wr_led) led <= led_w[LED_W-1:0];
      count <= wr_cnt ? merge(count, data_sram_wdata, bmask) : count + 32'(ctrl_en);
      if (wr_cmp) compare <= merge(compare, data_sram_wdata, bmask);
      if (wr_ctrl && data_sram_wen[0]) begin
        ctrl_en <= data_sram_wdata[0];
        ctrl_ie <= data_sram_wdata[1];
      end
      pending <= match | (pending & ~clr);
    end
  end
endmodule

// File: tb/tb_sram_mmio_responder.sv
// tb_sram_mmio_responder: directed and randomized checks against a behavioural port model
module tb_sram_mmio_responder;
  logic        clk = 0, resetn = 0, en = 0;
  logic [3:0]  wen = 0;
  logic [31:0] addr = 0, wdata = 0, rdata;
  logic [7:0]  sw = 0;
  logic [15:0] led;
  logic        irq;
  int          n_chk = 0, n_fail = 0;

  logic [31:0] m_mem [int];
  logic [31:0] m_rdata, m_count, m_cmp;
  logic [15:0] m_led;
  logic        m_en, m_ie, m_pend;

  always #5 clk = ~clk;

  sram_mmio_responder dut (
    .clk(clk), .resetn(resetn), .data_sram_en(en), .data_sram_wen(wen),
    .data_sram_addr(addr), .data_sram_wdata(wdata), .data_sram_rdata(rdata),
    .switch_i(sw), .led_o(led), .timer_int(irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mrg(input logic [31:0] old, input logic [31:0] d, input logic [3:0] w);
    logic [31:0] r = old;
    for (int i = 0; i < 4; i++) if (w[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // One clock of the port's behaviour, evaluated from the pre-edge state
  task automatic model_step();
    logic [31:0] rv, pre, t;
    logic [15:0] o;
    logic        mm, set, clr;
    int          idx;
    if (!resetn) begin
      m_rdata = 0; m_led = 0; m_count = 0; m_cmp = 32'hFFFF_FFFF;
      m_en = 0; m_ie = 0; m_pend = 0;
      return;
    end
    mm  = addr[31:16] == 16'hBFAF;
    o   = {addr[15:2], 2'b00};
    idx = int'(addr[13:2]);
    if (mm)
      rv = o == 16'hF000 ? {16'h0, m_led} : o == 16'hF004 ? {24'h0, sw} :
           o == 16'hE000 ? m_count : o == 16'hE004 ? m_cmp :
           o == 16'hE008 ? {29'h0, m_pend, m_ie, m_en} : 32'h0;
    else
      rv = m_mem.exists(idx) ? m_mem[idx] : 32'h0;
    if (en && wen == 0) m_rdata = rv;
    pre = m_count;
    set = m_en && pre == m_cmp;
    clr = 0;
    if (m_en) m_count = pre + 1;
    if (en && wen != 0) begin
      if (!mm) m_mem[idx] = mrg(m_mem.exists(idx) ? m_mem[idx] : 32'h0, wdata, wen);
      else if (o == 16'hF000) begin t = mrg({16'h0, m_led}, wdata, wen); m_led = t[15:0]; end
      else if (o == 16'hE000) m_count = mrg(pre, wdata, wen);
      else if (o == 16'hE004) m_cmp = mrg(m_cmp, wdata, wen);
      else if (o == 16'hE008 && wen[0]) begin
        m_en = wdata[0]; m_ie = wdata[1]; clr = wdata[2];
      end
    end
    m_pend = set | (m_pend & !clr);
  endtask

  task automatic step(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    en = e; wen = w; addr = a; wdata = d;
    model_step();
    @(posedge clk); #1;
    check("rdata", rdata, m_rdata);
    check("led", {16'h0, led}, {16'h0, m_led});
    check("timer_int", {31'h0, irq}, {31'h0, m_pend & m_ie});
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
    step(1, w, a, d);
  endtask

  task automatic rd(input logic [31:0] a);
    step(1, 4'h0, a, $urandom);
  endtask

  task automatic idle();
    step(0, 4'($urandom), $urandom, $urandom);
  endtask

  function automatic logic [31:0] ram_addr(input int i);
    logic [31:0] a = $urandom;
    if (a[31:16] == 16'hBFAF) a[31:16] = 16'h0;
    a[13:2] = 12'(i);
    return a;
  endfunction

  function automatic logic [31:0] mmio_addr();
    logic [15:0] offs [7] = '{16'hF000, 16'hF004, 16'hE000, 16'hE004, 16'hE008, 16'h1234, 16'hF008};
    logic [31:0] a = {16'hBFAF, offs[$urandom_range(0, 6)]};
    a[1:0] = 2'($urandom);
    return a;
  endfunction

  initial begin
    logic [31:0] a, d;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    resetn = 1;
    check("rst_rdata", rdata, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);

    wr(32'h0000_0040, 32'hDEAD_BEEF, 4'hF);
    rd(32'h0000_0040);
    check("ram_rt", rdata, 32'hDEAD_BEEF);
    idle(); idle();
    check("ram_hold", rdata, 32'hDEAD_BEEF);

    wr(32'h0000_0100, 32'h1122_3344, 4'hF);
    wr(32'h0000_0100, 32'hAABB_CCDD, 4'b0101);
    rd(32'h0000_0100);
    check("byte_en", rdata, 32'h11BB_33DD);

    wr(32'hBFAF_F000, 32'h0001_A5A5, 4'hF);
    check("led_set", {16'h0, led}, 32'h0000_A5A5);
    rd(32'hBFAF_F000);
    check("led_rd", rdata, 32'h0000_A5A5);
    sw = 8'h3C;
    rd(32'hBFAF_F004);
    check("switch_rd", rdata, 32'h0000_003C);

    wr(32'hBFAF_E004, 32'd5, 4'hF);
    wr(32'hBFAF_E000, 32'd0, 4'hF);
    wr(32'hBFAF_E008, 32'd3, 4'hF);
    for (int i = 0; i < 12 && !irq; i++) idle();
    check("irq_rise", {31'h0, irq}, 32'h1);
    rd(32'hBFAF_E000);
    wr(32'hBFAF_E008, 32'd7, 4'hF);
    check("irq_clr", {31'h0, irq}, 32'h0);

    wr(32'hBFAF_E004, 32'd50, 4'hF);
    wr(32'hBFAF_E000, 32'd50, 4'hF);
    wr(32'hBFAF_E008, 32'd7, 4'hF);
    check("set_wins", {31'h0, irq}, 32'h1);
    wr(32'hBFAF_E000, 32'h0000_1234, 4'hF);
    rd(32'hBFAF_E000);
    check("cnt_wr_wins", rdata, 32'h0000_1234);

    wr(32'hBFAF_F000, 32'h0000_FFFF, 4'hF);
    resetn = 0;
    rd(32'hBFAF_F000);
    check("rst_mid_rdata", rdata, 32'h0);
    check("rst_mid_led", {16'h0, led}, 32'h0);
    check("rst_mid_irq", {31'h0, irq}, 32'h0);
    resetn = 1;
    rd(32'h0000_0040);
    check("ram_keep", rdata, 32'hDEAD_BEEF);

    for (int i = 0; i < 16; i++) wr(ram_addr(i), $urandom, 4'hF);
    wr(32'hBFAF_E008, 32'd3, 4'hF);
    for (int n = 0; n < 3000; n++) begin
      a = $urandom_range(0, 2) == 0 ? mmio_addr() : ram_addr($urandom_range(0, 15));
      d = $urandom_range(0, 1) ? 32'($urandom_range(0, 40)) : $urandom;
      sw = 8'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        resetn = 0;
        step(1, 4'h0, a, d);
        resetn = 1;
      end else if ($urandom_range(0, 4) == 0) idle();
      else if ($urandom_range(0, 1) == 0) rd(a);
      else wr(a, d, 4'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
